// File: rtl/sap2_pkg.sv
`default_nettype none
// ============================================================================
// sap2_pkg : shared types and constants for the serial input path
// Revision : 1.0
// ============================================================================
package sap2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int   SERIAL_DATA_BITS = 8;
  localparam logic SERIAL_IDLE      = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock FIFO with wrap-bit pointers and a registered head
// Revision  : 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] head_n;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_n = do_push ? wr_ptr + PTR_ONE : wr_ptr;
  assign rd_ptr_n = do_pop  ? rd_ptr + PTR_ONE : rd_ptr;

  // Next head comes straight from din when it lands in the slot about to be read.
  always_comb begin
    head_n = mem[rd_ptr_n[AW-1:0]];
    if (do_push && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0]))
      head_n = din;
  end

  always_ff @(posedge CLK) begin
    if (do_push)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      if (wr_ptr_n != rd_ptr_n)
        dout <= head_n;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_receiver.sv
`default_nettype none
// ============================================================================
// serial_receiver : 8N1 oversampling receiver feeding a byte FIFO to input port 2
// Revision        : 1.0
// ============================================================================
module serial_receiver
  import sap2_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       serial_in,
  input  logic       rd_ack,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int             TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]  HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0]  FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  TIMER_ONE = TW'(1);
  localparam logic [2:0]     LAST_BIT  = 3'(SERIAL_DATA_BITS - 1);

  rx_state_t                     state, state_n;
  logic                          rx_meta, rx_s, rx_d;
  logic [TW-1:0]                 timer;
  logic [2:0]                    bit_idx;
  logic [SERIAL_DATA_BITS-1:0]   shreg;
  logic                          tick, push, frame_evt, sample, ovr_evt;
  logic                          fifo_full, fifo_empty;

  // rx_d lets IDLE require a high-to-low transition, so a low stop bit is never re-read as a start.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rx_meta <= SERIAL_IDLE;
      rx_s    <= SERIAL_IDLE;
      rx_d    <= SERIAL_IDLE;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  assign tick = (timer == '0);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!rx_s && rx_d) state_n = START;
      START:   if (tick) state_n = rx_s ? IDLE : DATA;
      DATA:    if (tick && (bit_idx == LAST_BIT)) state_n = STOP;
      STOP:    if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    sample    = (state == DATA) && tick;
    push      = (state == STOP) && tick && rx_s;
    frame_evt = (state == STOP) && tick && !rx_s;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE)
        timer <= (state_n == START) ? HALF_LOAD : '0;
      else if (tick)
        timer <= FULL_LOAD;
      else
        timer <= timer - TIMER_ONE;

      if (state == START)
        bit_idx <= '0;
      else if (sample)
        bit_idx <= bit_idx + 3'd1;

      if (sample)
        shreg <= {rx_s, shreg[SERIAL_DATA_BITS-1:1]};
    end
  end

  assign ovr_evt = push && fifo_full && !rd_ack;

  // Error events take priority over a coincident clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovr_evt)      overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;

      if (frame_evt)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (SERIAL_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .CLR   (CLR),
    .push  (push),
    .pop   (rd_ack),
    .din   (shreg),
    .dout  (data_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ready = !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver.sv
`default_nettype none
// ============================================================================
// tb_serial_receiver : directed bench for serial_receiver (16 clocks per bit)
// Revision           : 1.0
// ============================================================================
module tb_serial_receiver;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       serial_in = 1'b1;
  logic       rd_ack = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       ready, overrun, frame_err, busy;

  int checks = 0;
  int failures = 0;
  int first_ready = -1;

  serial_receiver #(
    .CLKS_PER_BIT (16),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .serial_in (serial_in),
    .rd_ack    (rd_ack),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .ready     (ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives one full 10-bit frame; optionally pulses rd_ack for the cycle after count ack_at.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_at);
    logic [9:0] bits;
    int k;
    bits = {stop_bit, b, 1'b0};
    k = 0;
    first_ready = -1;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 16; c++) begin
        serial_in = bits[i];
        @(posedge CLK);
        #1;
        k++;
        if (ready && first_ready < 0) first_ready = k;
        rd_ack = (k == ack_at);
      end
    end
    serial_in = 1'b1;
    rd_ack = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check(tag, data_out, exp);
    check({tag, "_ready"}, ready, 1'b1);
    rd_ack = 1'b1;
    cycles(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    logic [9:0] fr;

    cycles(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_ready", ready, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    CLR = 1'b0;
    cycles(5);

    // Reset in the middle of bit 4 of a 0x3C frame
    fr = {1'b1, 8'h3C, 1'b0};
    for (int k = 0; k < 88; k++) begin
      serial_in = fr[k / 16];
      cycles(1);
    end
    check("midframe_busy_before", busy, 1'b1);
    #2 CLR = 1'b1;
    #1;
    check("midframe_busy", busy, 1'b0);
    check("midframe_ready", ready, 1'b0);
    check("midframe_data", data_out, 8'h00);
    serial_in = 1'b1;
    cycles(2);
    CLR = 1'b0;
    cycles(20);
    send_frame(8'h81, 1'b1, -1);
    cycles(2);
    pop_expect("after_reset_81", 8'h81);
    check("after_reset_empty", ready, 1'b0);

    // Single frame with latency window
    send_frame(8'hA5, 1'b1, -1);
    check("a5_latency_in_window", (first_ready >= 154 && first_ready <= 158), 1'b1);
    check("a5_overrun", overrun, 1'b0);
    check("a5_frame_err", frame_err, 1'b0);
    pop_expect("a5_data", 8'hA5);
    check("a5_empty", ready, 1'b0);
    check("a5_hold_when_empty", data_out, 8'hA5);

    // Short low glitch
    serial_in = 1'b0;
    cycles(6);
    check("glitch_busy", busy, 1'b1);
    cycles(2);
    serial_in = 1'b1;
    cycles(30);
    check("glitch_idle", busy, 1'b0);
    check("glitch_ready", ready, 1'b0);
    check("glitch_frame_err", frame_err, 1'b0);
    check("glitch_overrun", overrun, 1'b0);

    // Framing error then clear
    send_frame(8'h5A, 1'b0, -1);
    cycles(20);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_ready", ready, 1'b0);
    check("ferr_busy", busy, 1'b0);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    check("ferr_cleared", frame_err, 1'b0);

    // Fill and overrun with back-to-back frames
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1, -1);
      if (v == 4) begin
        check("fill4_overrun", overrun, 1'b0);
        check("fill4_ready", ready, 1'b1);
      end
    end
    check("fill5_overrun", overrun, 1'b1);
    pop_expect("fill_rd1", 8'h01);
    pop_expect("fill_rd2", 8'h02);
    pop_expect("fill_rd3", 8'h03);
    pop_expect("fill_rd4", 8'h04);
    check("fill_drained", ready, 1'b0);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    check("ovr_cleared", overrun, 1'b0);

    // Push and pop together while full
    for (int v = 16; v <= 19; v++) send_frame(8'(v), 1'b1, -1);
    send_frame(8'h14, 1'b1, 154);
    check("simul_overrun", overrun, 1'b0);
    pop_expect("simul_rd1", 8'h11);
    pop_expect("simul_rd2", 8'h12);
    pop_expect("simul_rd3", 8'h13);
    pop_expect("simul_rd4", 8'h14);
    check("simul_drained", ready, 1'b0);

    // rd_ack on empty is ignored
    for (int n = 0; n < 3; n++) begin
      rd_ack = 1'b1;
      cycles(1);
      rd_ack = 1'b0;
      cycles(1);
      check("empty_ack_ready", ready, 1'b0);
    end
    send_frame(8'h77, 1'b1, -1);
    cycles(2);
    pop_expect("empty_ack_77", 8'h77);
    check("empty_ack_single", ready, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
